// File: rtl/elevator_request_queue.sv
// Button front end for the elevator controller: synchronize, debounce and edge-detect the
// hall and car buttons, then hold each press in a pending-request mask until serviced.
module elevator_request_queue #(
  parameter int floor      = 6,
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [floor-1:0] btnUp,
  input  logic [floor-1:0] btnDown,
  input  logic [floor-1:0] btnInside,
  input  logic [floor-1:0] clearFloor,
  input  logic             clearUp,
  input  logic             clearDown,
  input  logic             clearInside,
  output logic [floor-1:0] queueUp,
  output logic [floor-1:0] queueDown,
  output logic [floor-1:0] queueinside,
  output logic             newRequest,
  output logic             anyPending
);

  localparam int NB = 3 * floor;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
  // Top floor has no up button, bottom floor has no down button.
  localparam logic [floor-1:0] UP_OK = {1'b0, {(floor-1){1'b1}}};
  localparam logic [floor-1:0] DN_OK = {{(floor-1){1'b1}}, 1'b0};

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;

  assign w_raw = {btnInside, btnDown, btnUp};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  logic [NB-1:0] w_deb;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_deb
      // Only STABLE-1 past samples are stored; the live sample completes the window.
      logic [STABLE-2:0] r_hist;
      logic              r_level;
      logic [STABLE-1:0] w_window;

      assign w_window = {r_hist, r_sync2[gi]};

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_hist  <= '0;
          r_level <= 1'b0;
        end else if (w_tick) begin
          r_hist <= w_window[STABLE-2:0];
          if (&w_window) begin
            r_level <= 1'b1;
          end else if (~|w_window) begin
            r_level <= 1'b0;
          end
        end
      end

      assign w_deb[gi] = r_level;
    end
  endgenerate

  logic [NB-1:0]    r_deb_d;
  logic [NB-1:0]    w_press;
  logic [floor-1:0] w_press_up;
  logic [floor-1:0] w_press_dn;
  logic [floor-1:0] w_press_in;
  logic [floor-1:0] w_clr_up;
  logic [floor-1:0] w_clr_dn;
  logic [floor-1:0] w_clr_in;
  logic [floor-1:0] w_up_next;
  logic [floor-1:0] w_dn_next;
  logic [floor-1:0] w_in_next;
  logic [floor-1:0] r_q_up;
  logic [floor-1:0] r_q_dn;
  logic [floor-1:0] r_q_in;
  logic             w_rose;
  logic             r_new;

  assign w_press    = w_deb & ~r_deb_d;
  assign w_press_up = w_press[floor-1:0] & UP_OK;
  assign w_press_dn = w_press[2*floor-1:floor] & DN_OK;
  assign w_press_in = w_press[3*floor-1:2*floor];

  assign w_clr_up = {floor{clearUp}} & clearFloor;
  assign w_clr_dn = {floor{clearDown}} & clearFloor;
  assign w_clr_in = {floor{clearInside}} & clearFloor;

  // Clear dominates a coincident press: the car is already standing at that floor.
  assign w_up_next = (r_q_up | w_press_up) & ~w_clr_up;
  assign w_dn_next = (r_q_dn | w_press_dn) & ~w_clr_dn;
  assign w_in_next = (r_q_in | w_press_in) & ~w_clr_in;

  assign w_rose = |((w_up_next & ~r_q_up) | (w_dn_next & ~r_q_dn) | (w_in_next & ~r_q_in));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_deb_d <= '0;
      r_q_up  <= '0;
      r_q_dn  <= '0;
      r_q_in  <= '0;
      r_new   <= 1'b0;
    end else begin
      r_deb_d <= w_deb;
      r_q_up  <= w_up_next;
      r_q_dn  <= w_dn_next;
      r_q_in  <= w_in_next;
      r_new   <= w_rose;
    end
  end

  assign queueUp     = r_q_up;
  assign queueDown   = r_q_dn;
  assign queueinside = r_q_in;
  assign newRequest  = r_new;
  assign anyPending  = |{r_q_up, r_q_dn, r_q_in};

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: directed scenarios plus random button/clear traffic,
// every cycle compared against a run-length debounce model of the request queue.
module tb_elevator_request_queue;

  localparam int F  = 6;
  localparam int SD = 4;
  localparam int ST = 3;
  localparam int NB = 3 * F;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [F-1:0] btnUp = '0, btnDown = '0, btnInside = '0, clearFloor = '0;
  logic         clearUp = 1'b0, clearDown = 1'b0, clearInside = 1'b0;
  logic [F-1:0] queueUp, queueDown, queueinside;
  logic         newRequest, anyPending;

  int n_checks = 0;
  int n_errors = 0;
  int nreq_seen = 0;

  elevator_request_queue #(.floor(F), .SAMPLE_DIV(SD), .STABLE(ST)) dut (
    .clock      (clock),
    .reset      (reset),
    .btnUp      (btnUp),
    .btnDown    (btnDown),
    .btnInside  (btnInside),
    .clearFloor (clearFloor),
    .clearUp    (clearUp),
    .clearDown  (clearDown),
    .clearInside(clearInside),
    .queueUp    (queueUp),
    .queueDown  (queueDown),
    .queueinside(queueinside),
    .newRequest (newRequest),
    .anyPending (anyPending)
  );

  always #5 clock = ~clock;

  // Model: each button bit tracks the value and length of its current run of equal samples.
  logic [NB-1:0] m_d1, m_d2, m_level, m_rose;
  logic          m_run_val [NB];
  int            m_run_len [NB];
  int            m_cnt;
  logic [F-1:0]  m_qu, m_qd, m_qi;
  logic          m_new;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_level = '0; m_rose = '0;
    m_cnt = 0; m_qu = '0; m_qd = '0; m_qi = '0; m_new = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_run_val[b] = 1'b0;
      m_run_len[b] = ST;
    end
  endtask

  task automatic model_step();
    logic [F-1:0] p_up, p_dn, p_in, n_up, n_dn, n_in;
    logic tick;
    p_up = m_rose[F-1:0] & 6'b011111;
    p_dn = m_rose[2*F-1:F] & 6'b111110;
    p_in = m_rose[3*F-1:2*F];
    n_up = (m_qu | p_up) & ~(clearUp ? clearFloor : 6'b0);
    n_dn = (m_qd | p_dn) & ~(clearDown ? clearFloor : 6'b0);
    n_in = (m_qi | p_in) & ~(clearInside ? clearFloor : 6'b0);
    m_new = ((n_up & ~m_qu) | (n_dn & ~m_qd) | (n_in & ~m_qi)) != 6'b0;
    m_qu = n_up; m_qd = n_dn; m_qi = n_in;
    tick = (m_cnt == SD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_rose = '0;
    if (tick) begin
      for (int b = 0; b < NB; b++) begin
        if (m_d2[b] == m_run_val[b]) begin
          if (m_run_len[b] < ST) m_run_len[b]++;
        end else begin
          m_run_val[b] = m_d2[b];
          m_run_len[b] = 1;
        end
        if (m_run_len[b] >= ST && m_level[b] != m_run_val[b]) begin
          m_level[b] = m_run_val[b];
          m_rose[b]  = m_run_val[b];
        end
      end
    end
    m_d2 = m_d1;
    m_d1 = {btnInside, btnDown, btnUp};
  endtask

  task automatic compare_all();
    check("queueUp", 32'(queueUp), 32'(m_qu));
    check("queueDown", 32'(queueDown), 32'(m_qd));
    check("queueinside", 32'(queueinside), 32'(m_qi));
    check("newRequest", 32'(newRequest), 32'(m_new));
    check("anyPending", 32'(anyPending), 32'((m_qu | m_qd | m_qi) != 6'b0));
  endtask

  task automatic tick_cycle();
    @(negedge clock);
    if (reset) model_reset();
    else model_step();
    compare_all();
    if (newRequest === 1'b1) nreq_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  // Assert reset between clock edges and confirm the outputs drop without waiting for an edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_queueUp", 32'(queueUp), 32'd0);
    check("rst_queueDown", 32'(queueDown), 32'd0);
    check("rst_queueinside", 32'(queueinside), 32'd0);
    check("rst_newRequest", 32'(newRequest), 32'd0);
    check("rst_anyPending", 32'(anyPending), 32'd0);
  endtask

  function automatic logic [F-1:0] rand_flip();
    logic [F-1:0] v;
    v = '0;
    for (int i = 0; i < F; i++) v[i] = ($urandom_range(0, 23) == 0);
    return v;
  endfunction

  int lat;

  initial begin
    // 1: reset value and idle
    #1;
    async_reset();
    run(2);
    reset = 1'b0;
    run(50);
    $display("phase reset_idle checks=%0d", n_checks);

    // 2: clean press with latency bound
    nreq_seen = 0;
    lat = -1;
    btnInside = 6'b000100;
    for (int k = 1; k <= 30; k++) begin
      tick_cycle();
      if (lat < 0 && queueinside[2] === 1'b1) lat = k;
    end
    check("press_latency_in_range", 32'(lat >= 12 && lat <= 16), 32'd1);
    check("clean_press_queue", 32'(queueinside), 32'(6'b000100));
    check("clean_press_pulses", 32'(nreq_seen), 32'd1);
    check("clean_press_pending", 32'(anyPending), 32'd1);
    btnInside = '0;
    run(20);
    $display("phase clean_press latency=%0d", lat);

    // 3: bounce rejection, then steady hold
    nreq_seen = 0;
    for (int c = 0; c < 40; c++) begin
      btnUp[1] = ((c / 3) % 2) == 0;
      tick_cycle();
    end
    btnUp = '0;
    run(20);
    check("bounce_queue", 32'(queueUp), 32'd0);
    check("bounce_pulses", 32'(nreq_seen), 32'd0);
    btnUp[1] = 1'b1;
    run(30);
    check("steady_up", 32'(queueUp), 32'(6'b000010));
    btnUp = '0;
    run(20);
    $display("phase bounce done");

    // 4: clear while button still held, then re-press
    btnDown[3] = 1'b1;
    run(30);
    check("down_set", 32'(queueDown), 32'(6'b001000));
    clearDown = 1'b1;
    clearFloor = 6'b001000;
    tick_cycle();
    check("down_cleared", 32'(queueDown), 32'd0);
    clearDown = 1'b0;
    clearFloor = '0;
    run(20);
    check("down_stays_clear", 32'(queueDown), 32'd0);
    btnDown = '0;
    run(20);
    btnDown[3] = 1'b1;
    run(30);
    check("down_repress", 32'(queueDown), 32'(6'b001000));
    btnDown = '0;
    run(20);
    $display("phase clear_held done");

    // 5: press coinciding with clear on the same bit, independent press elsewhere
    clearInside = 1'b1;
    clearFloor = 6'b010000;
    btnInside[4] = 1'b1;
    btnUp[0] = 1'b1;
    run(30);
    check("press_vs_clear_in4", 32'(queueinside[4]), 32'd0);
    check("concurrent_up0", 32'(queueUp[0]), 32'd1);
    clearInside = 1'b0;
    clearFloor = '0;
    run(10);
    check("in4_no_late_press", 32'(queueinside[4]), 32'd0);
    btnInside = '0;
    btnUp = '0;
    run(20);
    $display("phase press_vs_clear done");

    // 6: masked buttons, then reset in the middle of a debounce
    btnUp[5] = 1'b1;
    btnDown[0] = 1'b1;
    run(40);
    check("masked_up5", 32'(queueUp[5]), 32'd0);
    check("masked_down0", 32'(queueDown[0]), 32'd0);
    btnUp = '0;
    btnDown = '0;
    run(20);
    btnInside[2] = 1'b1;
    run(6);
    async_reset();
    run(3);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick_cycle();
      check("post_reset_in2_low", 32'(queueinside[2]), 32'd0);
    end
    run(20);
    check("post_reset_in2_set", 32'(queueinside), 32'(6'b000100));
    btnInside = '0;
    run(20);
    $display("phase masked_reset done");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      btnUp     = btnUp ^ rand_flip();
      btnDown   = btnDown ^ rand_flip();
      btnInside = btnInside ^ rand_flip();
      if ($urandom_range(0, 5) == 0) begin
        clearFloor  = 6'(1 << $urandom_range(0, F - 1));
        clearUp     = 1'($urandom_range(0, 1));
        clearDown   = 1'($urandom_range(0, 1));
        clearInside = 1'($urandom_range(0, 1));
      end else begin
        clearFloor  = '0;
        clearUp     = 1'b0;
        clearDown   = 1'b0;
        clearInside = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        tick_cycle();
        reset = 1'b0;
      end
      tick_cycle();
    end
    $display("phase random done checks=%0d", n_checks);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
